// File: rtl/race_time_decoder_pkg.sv
// Shared definitions for the race-logic time decoder: FSM states, default
// geometry and the timeout count.
package race_time_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 4;
  localparam int DEF_TIMEOUT = (1 << DEF_W) - 1;

  // Timeout is the largest count a W-bit timestamp can hold.
  function automatic int timeout_count(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/race_time_decoder_capture.sv
// One race line: a sticky valid flag plus the count at which the line first
// rose; also exposes its next-state values for the top-level order check.
module race_capture_cell
  import race_time_decoder_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_capture_en,
  input  logic         i_force_ones,
  input  logic         i_line,
  input  logic [W-1:0] i_count,
  output logic         o_valid,
  output logic [W-1:0] o_time,
  output logic         o_valid_d,
  output logic [W-1:0] o_time_d
);

  logic         r_valid;
  logic [W-1:0] r_time;
  logic         w_cap;
  logic         w_valid_d;
  logic [W-1:0] w_time_d;

  assign w_cap     = i_capture_en & ~r_valid & i_line;
  assign w_valid_d = i_clear ? 1'b0 : (r_valid | w_cap);

  // Valid is kept out of this block so the close decision, which depends on
  // valid, never feeds back through the time path.
  always_comb begin
    w_time_d = r_time;
    if (i_clear) begin
      w_time_d = '0;
    end else if (w_cap) begin
      w_time_d = i_count;
    end else if (i_force_ones && !r_valid) begin
      w_time_d = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_time  <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_time  <= w_time_d;
    end
  end

  assign o_valid   = r_valid;
  assign o_time    = r_time;
  assign o_valid_d = w_valid_d;
  assign o_time_d  = w_time_d;

endmodule

// File: rtl/race_time_decoder.sv
// Timestamps rising edges of the sorter's race wires against a local counter
// and reports whether the captured order is non-decreasing.
module race_time_decoder
  import race_time_decoder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   lines,
  output logic [N*W-1:0] times,
  output logic [N-1:0]   valid,
  output logic           busy,
  output logic           done,
  output logic           sorted_ok
);

  localparam logic [W-1:0] TIMEOUT = W'(timeout_count(W));

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_count;
  logic         r_sorted_ok;

  logic         w_run;
  logic         w_start_acc;
  logic         w_all_cap;
  logic         w_timeout;
  logic         w_close;
  logic         w_sorted_d;
  logic [N-1:0] w_valid;
  logic [N-1:0] w_valid_d;
  logic [W-1:0] w_time   [N];
  logic [W-1:0] w_time_d [N];

  assign w_run       = (r_state == ST_RUN);
  assign w_start_acc = start & ~w_run;
  assign w_all_cap   = &w_valid_d;
  assign w_timeout   = (r_count == TIMEOUT);
  assign w_close     = w_run & (w_all_cap | w_timeout);

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    race_capture_cell #(
      .W (W)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start_acc),
      .i_capture_en (w_run),
      .i_force_ones (w_close),
      .i_line       (lines[gi]),
      .i_count      (r_count),
      .o_valid      (w_valid[gi]),
      .o_time       (w_time[gi]),
      .o_valid_d    (w_valid_d[gi]),
      .o_time_d     (w_time_d[gi])
    );
    assign times[gi*W +: W] = w_time[gi];
  end

  // Order check over the capture set as it will stand after this edge.
  always_comb begin
    w_sorted_d = &w_valid_d;
    for (int i = 0; i < N - 1; i++) begin
      if (w_time_d[i] > w_time_d[i+1]) begin
        w_sorted_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_close) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  // Counter saturates at the timeout value rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_start_acc) begin
      r_count <= '0;
    end else if (w_run && !w_timeout) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sorted_ok <= 1'b0;
    end else if (w_start_acc) begin
      r_sorted_ok <= 1'b0;
    end else if (w_close) begin
      r_sorted_ok <= w_sorted_d;
    end
  end

  assign valid     = w_valid;
  assign sorted_ok = r_sorted_ok;

endmodule

// File: tb/tb_race_time_decoder.sv
// Scoreboard bench for race_time_decoder: directed and random measurement
// windows against a first-rise reference model.
module tb_race_time_decoder;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int TMAX  = (1 << W) - 1;
  localparam int NEVER = 1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   lines = '0;
  logic [N*W-1:0] times;
  logic [N-1:0]   valid;
  logic           busy;
  logic           done;
  logic           sorted_ok;

  race_time_decoder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lines     (lines),
    .times     (times),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .sorted_ok (sorted_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N*W-1:0] times;
    logic [N-1:0]   valid;
    logic           ok;
    int             cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr[N];
  int   wf[N];
  int   wg[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Line i level at RUN sample t (t = -1 is the start cycle itself).
  function automatic logic val(input int i, input int t);
    return (t >= wr[i]) && !(t >= wf[i] && t < wg[i]);
  endfunction

  function automatic logic [N-1:0] line_vec(input int t);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = val(i, t);
    return v;
  endfunction

  task automatic set_win(input int a, input int b, input int c, input int d);
    wr[0] = a; wr[1] = b; wr[2] = c; wr[3] = d;
    for (int i = 0; i < N; i++) begin
      wf[i] = NEVER;
      wg[i] = NEVER;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge entering DONE.
  task automatic issue(input bit noise);
    exp_t e;
    int   cap[N];
    int   endt;
    bit   all;
    all  = 1'b1;
    endt = 0;
    for (int i = 0; i < N; i++) begin
      cap[i] = -1;
      for (int t = 0; t <= TMAX; t++) begin
        if (cap[i] < 0 && val(i, t)) cap[i] = t;
      end
      if (cap[i] < 0) all = 1'b0;
      else if (cap[i] > endt) endt = cap[i];
    end
    if (!all) endt = TMAX;
    e.ok = all;
    for (int i = 0; i < N; i++) begin
      e.valid[i]        = (cap[i] >= 0);
      e.times[i*W +: W] = (cap[i] >= 0) ? W'(cap[i]) : W'(TMAX);
      if (i < N - 1 && cap[i] > cap[i+1]) e.ok = 1'b0;
    end
    e.cyc = cyc + 2 + endt;
    q.push_back(e);

    start = 1'b1;
    lines = line_vec(-1);
    @(posedge clk); #1;
    chk("open_valid_clear", valid, 0);
    chk("open_times_clear", times, 0);
    chk("open_sorted_clear", sorted_ok, 0);
    chk("open_busy", busy, 1);
    for (int t = 0; t <= endt; t++) begin
      if (t > 0) chk("run_busy", busy, 1);
      start = noise && ($urandom_range(0, 3) == 0);
      lines = line_vec(t);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_busy_low", busy, 0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required no pending window (t=%0t)", $time);
      end else begin
        m_e = q.pop_front();
        chk("times", times, m_e.times);
        chk("valid", valid, m_e.valid);
        chk("sorted_ok", sorted_ok, m_e.ok);
        chk("done_cycle", cyc, m_e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int tmp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_times", times, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sorted", sorted_ok, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sorted window, then results must hold while idle.
    set_win(1, 3, 3, 7);
    issue(1'b0);
    @(posedge clk); #1;
    chk("hold_done_low", done, 0);
    chk("hold_busy_low", busy, 0);
    chk("hold_sorted", sorted_ok, 1);
    chk("hold_valid", valid, 4'hF);
    chk("hold_times", times, 16'h7331);

    set_win(0, 5, 2, 6);
    issue(1'b0);
    @(posedge clk); #1;

    set_win(3, 4, 2, NEVER);
    issue(1'b0);
    @(posedge clk); #1;
    chk("timeout_hold_valid", valid, 4'b0111);
    chk("timeout_hold_time3", times[15:12], 4'hF);

    set_win(1, 2, 3, 15);
    issue(1'b0);
    @(posedge clk); #1;

    set_win(15, NEVER, 0, 0);
    issue(1'b0);
    @(posedge clk); #1;

    set_win(2, 3, 5, 8);
    wf[0] = 4;
    wg[0] = 6;
    issue(1'b0);
    @(posedge clk); #1;
    chk("glitch_time0", times[3:0], 4'd2);

    set_win(-1, 0, -1, 4);
    issue(1'b0);
    @(posedge clk); #1;

    // Abort a window with reset at count 5.
    start = 1'b1;
    lines = '0;
    @(posedge clk); #1;
    start = 1'b0;
    lines = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_valid", valid, 4'b0001);
    rst = 1'b1;
    #1;
    chk("abort_times", times, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sorted", sorted_ok, 0);
    #2;
    rst = 1'b0;
    lines = '0;
    @(posedge clk); #1;
    chk("after_abort_busy", busy, 0);
    chk("after_abort_done", done, 0);
    set_win(4, 4, 9, 10);
    issue(1'b0);
    @(posedge clk); #1;

    // Back-to-back windows with start noise during RUN.
    set_win(2, 6, 1, 3);
    issue(1'b1);
    set_win(0, 1, 1, 2);
    issue(1'b1);
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        r = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 20));
        wr[i] = r;
        if ($urandom_range(0, 4) == 0) begin
          wf[i] = r + 1 + int'($urandom_range(0, 3));
          wg[i] = wf[i] + 1 + int'($urandom_range(0, 5));
        end else begin
          wf[i] = NEVER;
          wg[i] = NEVER;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int a = 0; a < N - 1; a++) begin
          for (int b = 0; b < N - 1 - a; b++) begin
            if (wr[b] > wr[b+1]) begin
              tmp = wr[b]; wr[b] = wr[b+1]; wr[b+1] = tmp;
            end
          end
        end
      end
      issue(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
